leitor_teclado_4x4: RTL

- Scans a 4x4 matrix keypad, debounces it and produces a 4-bit key code.
- The code uses the same encoding as the `contagem` input of display_7seg, so the display can be driven straight from it.
- This is the input side of the board, opposite to the display path.
- It sits in top-level designs next to the clock divider.

---
 rtl/teclado_pkg.sv | 55 +++++
 rtl/leitor_teclado_4x4_sincronizador_2ff.sv | 28 ++
 rtl/leitor_teclado_4x4.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/teclado_pkg.sv
// Shared types, key codes and decode helpers for the 4x4 keypad reader.
// Key codes follow the display_7seg digit encoding so they can drive it directly.
package teclado_pkg;

  typedef enum logic [1:0] {
    VARRE,
    DEBOUNCE,
    PRESSIONADA,
    LIBERA
  } estado_t;

  localparam logic [3:0] TECLA_A    = 4'd10;
  localparam logic [3:0] TECLA_B    = 4'd11;
  localparam logic [3:0] TECLA_C    = 4'd12;
  localparam logic [3:0] TECLA_D    = 4'd13;
  localparam logic [3:0] TECLA_STAR = 4'd14;
  localparam logic [3:0] TECLA_HASH = 4'd15;

  // True when exactly one active-low row is asserted.
  function automatic logic one_hot_valido(input logic [3:0] lin);
    case (lin)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: one_hot_valido = 1'b1;
      default:                            one_hot_valido = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] mapa(input logic [3:0] lin, input logic [1:0] col);
    logic [1:0] row;
    case (lin)
      4'b1101: row = 2'd1;
      4'b1011: row = 2'd2;
      4'b0111: row = 2'd3;
      default: row = 2'd0;
    endcase
    case ({row, col})
      4'h0: mapa = 4'd1;
      4'h1: mapa = 4'd2;
      4'h2: mapa = 4'd3;
      4'h3: mapa = TECLA_A;
      4'h4: mapa = 4'd4;
      4'h5: mapa = 4'd5;
      4'h6: mapa = 4'd6;
      4'h7: mapa = TECLA_B;
      4'h8: mapa = 4'd7;
      4'h9: mapa = 4'd8;
      4'hA: mapa = 4'd9;
      4'hB: mapa = TECLA_C;
      4'hC: mapa = TECLA_STAR;
      4'hD: mapa = 4'd0;
      4'hE: mapa = TECLA_HASH;
      default: mapa = TECLA_D;
    endcase
  endfunction

endpackage

// File: rtl/leitor_teclado_4x4_sincronizador_2ff.sv
// Two-flop synchronizer for asynchronous inputs; resets to all-ones so
// pulled-up lines read as idle straight out of reset.
module sincronizador_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/leitor_teclado_4x4.sv
// 4x4 matrix keypad scanner with debounce; emits a held key code and a
// one-clock pulse per accepted press.
module leitor_teclado_4x4
  import teclado_pkg::*;
#(
  parameter int FREQ_CLK_HZ = 25_000_000,
  parameter int SCAN_HZ     = 1000,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] linhas,
  output logic [3:0] colunas,
  output logic [3:0] tecla,
  output logic       tecla_valida,
  output logic       tecla_pressionada
);

  localparam int SCAN_DIV = FREQ_CLK_HZ / SCAN_HZ;
  localparam int DEB_CYC  = DEBOUNCE_MS * FREQ_CLK_HZ / 1000;
  localparam int SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W    = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEB_CYC - 1);

  if (SCAN_DIV < 4) begin : g_chk_scan
    $error("leitor_teclado_4x4: SCAN_DIV must be >= 4");
  end
  if (DEB_CYC < 1) begin : g_chk_deb
    $error("leitor_teclado_4x4: DEB_CYC must be >= 1");
  end

  logic [3:0] lin_s;

  sincronizador_2ff #(.WIDTH(4)) u_sync_linhas (
    .clk   (clk),
    .reset (reset),
    .d_i   (linhas),
    .q_o   (lin_s)
  );

  estado_t           state_q, state_d;
  logic [1:0]        col_q, col_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [DEB_W-1:0]  deb_q, deb_d;
  logic [3:0]        lin_cap_q, lin_cap_d;
  logic [1:0]        col_cap_q, col_cap_d;
  logic [3:0]        tecla_q, tecla_d;
  logic              valida_q, valida_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= VARRE;
      col_q     <= 2'd0;
      scan_q    <= '0;
      deb_q     <= '0;
      lin_cap_q <= 4'hF;
      col_cap_q <= 2'd0;
      tecla_q   <= 4'd0;
      valida_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      scan_q    <= scan_d;
      deb_q     <= deb_d;
      lin_cap_q <= lin_cap_d;
      col_cap_q <= col_cap_d;
      tecla_q   <= tecla_d;
      valida_q  <= valida_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d   = state_q;
    col_d     = col_q;
    scan_d    = scan_q;
    deb_d     = deb_q;
    lin_cap_d = lin_cap_q;
    col_cap_d = col_cap_q;
    tecla_d   = tecla_q;
    valida_d  = 1'b0;
    unique case (state_q)
      VARRE: begin
        if (scan_q == SCAN_MAX) begin
          scan_d = '0;
          // Idle and multi-row (ghosting) samples both just move to the next column.
          if (one_hot_valido(lin_s)) begin
            lin_cap_d = lin_s;
            col_cap_d = col_q;
            deb_d     = '0;
            state_d   = DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          scan_d = scan_q + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (lin_s != lin_cap_q) begin
          state_d = VARRE;
          col_d   = col_q + 2'd1;
          scan_d  = '0;
        end else if (deb_q == DEB_MAX) begin
          tecla_d  = mapa(lin_cap_q, col_cap_q);
          valida_d = 1'b1;
          state_d  = PRESSIONADA;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      PRESSIONADA: begin
        if (lin_s == 4'hF) begin
          deb_d   = '0;
          state_d = LIBERA;
        end
      end
      LIBERA: begin
        if (lin_s != 4'hF) begin
          state_d = PRESSIONADA;
        end else if (deb_q == DEB_MAX) begin
          state_d = VARRE;
          col_d   = col_q + 2'd1;
          scan_d  = '0;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      default: state_d = VARRE;
    endcase
  end

  always_comb begin
    colunas           = ~(4'b0001 << col_q);
    tecla_pressionada = (state_q == PRESSIONADA) || (state_q == LIBERA);
    tecla             = tecla_q;
    tecla_valida      = valida_q;
  end

endmodule
